// File: rtl/if_pkg.sv
// Shared constants and helpers for the instruction fetch front end.
package if_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Reverse byte order: {b3,b2,b1,b0} -> {b0,b1,b2,b3}.
  function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {inst, pc} pairs; head is a register so
// the output stays stable while decode stalls.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else if (clr) begin
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= din;
          else                   tail_reg <= din;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, data shifts forward.
          if (count_reg == 2'd2) begin
            head_reg <= tail_reg;
            tail_reg <= din;
          end else begin
            head_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_reg;
  assign head  = head_reg;

endmodule

// File: rtl/inst_fetch.sv
// MIPS32 instruction fetch: PC sequencing, ROM issue, redirect/flush.
// Define IFETCH_BSWAP_EN to byte-reverse ROM words at push (little-endian image).
module inst_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc
);

  logic [31:0]         fetch_pc_reg;
  logic                req_vld_reg;
  logic [31:0]         req_pc_reg;
  logic [1:0]          count;
  logic [2:0]          occupancy;
  logic                pop;
  logic                push;
  logic                issue;
  logic [INST_W-1:0]   inst_word;
  logic [INST_W+31:0]  head;

  assign if_valid = (count != 2'd0);
  assign pop      = if_valid && if_ready;
  assign push     = req_vld_reg && !redirect_valid;

  // An outstanding read is counted as occupied so its push always finds room.
  assign occupancy = {1'b0, count} + {2'b00, req_vld_reg};
  assign issue     = !redirect_valid && (occupancy < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      req_vld_reg  <= 1'b0;
      req_pc_reg   <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
      req_vld_reg  <= 1'b0;
    end else if (issue) begin
      fetch_pc_reg <= fetch_pc_reg + 32'd4;
      req_vld_reg  <= 1'b1;
      req_pc_reg   <= fetch_pc_reg;
    end else begin
      req_vld_reg  <= 1'b0;
    end
  end

`ifdef IFETCH_BSWAP_EN
  assign inst_word = bswap32(rom_data);
`else
  assign inst_word = rom_data;
`endif

  fetch_fifo #(
    .W (INST_W + 32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({inst_word, req_pc_reg}),
    .count (count),
    .head  (head)
  );

  assign rom_addr = fetch_pc_reg[ADDR_W+1:2];
  assign if_inst  = head[INST_W+31:32];
  assign if_pc    = head[31:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a registered-read ROM model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;

`ifdef IFETCH_BSWAP_EN
  localparam logic [31:0] TEST_WORD_EXP = 32'h4086_6000;
`else
  localparam logic [31:0] TEST_WORD_EXP = 32'h0060_8640;
`endif

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(posedge clk)
    if (!rst && if_valid && if_ready)
      $display("pop  pc=%08h inst=%08h", if_pc, if_inst);

  // Expected instruction for ROM word n, whose contents are n+1.
  function automatic logic [31:0] word_exp(input int n);
    logic [31:0] v;
    v = n + 1;
`ifdef IFETCH_BSWAP_EN
    v = {v[7:0], v[15:8], v[23:16], v[31:24]};
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_inst"}, if_inst, inst);
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i + 1;
    rst = 1'b1;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();

    // Reset state
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_addr", {24'h0, rom_addr}, 32'h0);

    // Latency: cycle 0 issue, cycle 1 push, cycle 2 valid
    rst = 1'b0;
    step();
    expect_empty("lat_c1");
    step();

    // Sequential fetch at full rate
    for (int n = 0; n < 3; n++) begin
      expect_head($sformatf("seq%0d", n), 32'(4 * n), word_exp(n));
      step();
    end

    // Stall for 5 cycles: head stable and rom_addr frozen at word 5
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_head($sformatf("stall%0d", k), 32'd12, word_exp(3));
      check($sformatf("stall%0d_addr", k), {24'h0, rom_addr}, 32'd5);
      step();
    end
    if_ready = 1'b1;
    for (int n = 3; n < 10; n++) begin
      expect_head($sformatf("resume%0d", n), 32'(4 * n), word_exp(n));
      step();
    end

    // Fill buffer to two entries, then redirect to 0x100
    if_ready = 1'b0;
    step();
    expect_head("fill", 32'd40, word_exp(10));
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    expect_empty("rdr_r1");
    step();
    expect_empty("rdr_r2");
    step();
    expect_head("rdr_r3", 32'h100, word_exp(64));
    step();
    expect_head("rdr_next", 32'h104, word_exp(65));
    step();

    // Redirect in the same cycle as a pop
    expect_head("rdpop_head", 32'h108, word_exp(66));
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    expect_empty("rdpop_r1");
    step();
    expect_empty("rdpop_r2");
    step();
    expect_head("rdpop_r3", 32'h200, word_exp(128));
    step();
    expect_head("rdpop_next", 32'h204, word_exp(129));

    // Misaligned redirect and ROM address wrap; word 0 holds the swap test pattern
    mem[0] = 32'h0060_8640;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FE;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_ff", {24'h0, rom_addr}, 32'hFF);
    step();
    check("wrap_addr_00", {24'h0, rom_addr}, 32'h00);
    step();
    expect_head("wrap_3fc", 32'h3FC, word_exp(255));
    step();
    expect_head("wrap_400", 32'h400, TEST_WORD_EXP);
    step();
    expect_head("wrap_404", 32'h404, word_exp(1));

    // Mid-stream reset discards everything
    rst = 1'b1;
    step();
    check("mrst_valid", {31'h0, if_valid}, 32'h0);
    check("mrst_inst", if_inst, 32'h0);
    check("mrst_pc", if_pc, 32'h0);
    check("mrst_addr", {24'h0, rom_addr}, 32'h0);
    rst = 1'b0;
    step();
    expect_empty("mrst_c1");
    step();
    expect_head("mrst_first", 32'h0, TEST_WORD_EXP);
    step();
    expect_head("mrst_second", 32'h4, word_exp(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
